// File: rtl/btn_step_counter.sv
// btn_step_counter
//   Synchronises and debounces a raw, bouncy push-button. Each accepted press produces a
//   single-cycle step pulse and adds STEP to a DATA_BITS-wide step counter. The counter feeds
//   the 7-segment display path.
//
// Ports
//   clk         system clock, all logic on posedge
//   rst         asynchronous active-low reset (0 = reset)
//   btn         raw push-button, active high, asynchronous to clk
//   clr         synchronous clear of num, active high, clk domain
//   num         step counter value (wraps modulo 2^DATA_BITS)
//   step_pulse  high for exactly one cycle per accepted step
//   pressed     debounced button level
//
// Build option
//   AUTO_REPEAT_EN  when defined, holding the button in the pressed state fires a step after
//                   REPEAT_DELAY cycles and then every REPEAT_PERIOD cycles.

module btn_step_counter #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned CNT_W           = 20,
    parameter int unsigned DATA_BITS       = 32,
    parameter int unsigned STEP            = 4,
    parameter int unsigned REPEAT_DELAY    = 100000000,
    parameter int unsigned REPEAT_PERIOD   = 40000000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 btn,
    input  logic                 clr,
    output logic [DATA_BITS-1:0] num,
    output logic                 step_pulse,
    output logic                 pressed
);

    // Elaboration-time sanity checks on the configuration.
    if (DEBOUNCE_CYCLES < 2 || (64'(DEBOUNCE_CYCLES) - 64'd1) >= (64'd1 << CNT_W) ||
        REPEAT_DELAY == 0 || REPEAT_PERIOD == 0) begin : g_param_check
        $error("btn_step_counter: invalid parameter combination");
    end

    typedef enum logic [1:0] {
        StIdle        = 2'd0,
        StPressWait   = 2'd1,
        StPressed     = 2'd2,
        StReleaseWait = 2'd3
    } state_e;

    state_e               state_q;
    logic                 sync1_q;
    logic                 sync2_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [DATA_BITS-1:0] num_q;
    logic                 step_q;
    logic                 pressed_q;

    logic                 btn_s;
    logic                 cnt_done;
    logic                 step_fire;

    assign btn_s      = sync2_q;
    assign cnt_done   = (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1));
    assign num        = num_q;
    assign step_pulse = step_q;
    assign pressed    = pressed_q;

`ifdef AUTO_REPEAT_EN
    // hold_q counts cycles spent in StPressed; rep_q marks that the first repeat has fired,
    // switching the target from REPEAT_DELAY to REPEAT_PERIOD.
    logic [31:0] hold_q;
    logic        rep_q;
    logic        hold_done;

    assign hold_done = rep_q ? (hold_q == 32'(REPEAT_PERIOD - 1))
                             : (hold_q == 32'(REPEAT_DELAY - 1));
`endif

    always_comb begin
        step_fire = 1'b0;
        if (state_q == StPressWait && btn_s && cnt_done) begin
            step_fire = 1'b1;
        end
`ifdef AUTO_REPEAT_EN
        if (state_q == StPressed && btn_s && hold_done) begin
            step_fire = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            state_q   <= StIdle;
            cnt_q     <= '0;
            num_q     <= '0;
            step_q    <= 1'b0;
            pressed_q <= 1'b0;
`ifdef AUTO_REPEAT_EN
            hold_q    <= '0;
            rep_q     <= 1'b0;
`endif
        end else begin
            sync1_q <= btn;
            sync2_q <= sync1_q;
            step_q  <= step_fire;

            // clr wins over a simultaneous step; the pulse itself is unaffected.
            if (clr) begin
                num_q <= '0;
            end else if (step_fire) begin
                num_q <= num_q + DATA_BITS'(STEP);
            end

            // pressed_q tracks whether the next state is StPressed or StReleaseWait.
            unique case (state_q)
                StIdle: begin
                    pressed_q <= 1'b0;
                    if (btn_s) begin
                        state_q <= StPressWait;
                        cnt_q   <= '0;
                    end
                end
                StPressWait: begin
                    pressed_q <= btn_s && cnt_done;
                    if (!btn_s) begin
                        state_q <= StIdle;
                    end else if (cnt_done) begin
                        state_q <= StPressed;
`ifdef AUTO_REPEAT_EN
                        hold_q  <= '0;
                        rep_q   <= 1'b0;
`endif
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                StPressed: begin
                    pressed_q <= 1'b1;
                    if (!btn_s) begin
                        state_q <= StReleaseWait;
                        cnt_q   <= '0;
                    end
`ifdef AUTO_REPEAT_EN
                    else if (hold_done) begin
                        hold_q <= '0;
                        rep_q  <= 1'b1;
                    end else begin
                        hold_q <= hold_q + 32'd1;
                    end
`endif
                end
                StReleaseWait: begin
                    // Hold counter (if present) is frozen here and resumes on return.
                    pressed_q <= btn_s || !cnt_done;
                    if (btn_s) begin
                        state_q <= StPressed;
                    end else if (cnt_done) begin
                        state_q <= StIdle;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_q   <= StIdle;
                    pressed_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_btn_step_counter.sv
// Directed testbench for btn_step_counter with DEBOUNCE_CYCLES=8. A second instance with a
// 4-bit counter exercises wrap-around (0xC + 4 -> 0x0).

module tb_btn_step_counter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        btn = 1'b0;
    logic        clr = 1'b0;
    logic [31:0] num;
    logic        step_pulse;
    logic        pressed;
    logic [3:0]  num_n;
    logic        step_n;
    logic        pressed_n;

    int n_checks  = 0;
    int n_errors  = 0;
    int edge_cnt  = 0;
    int pulse_cnt = 0;

    btn_step_counter #(
        .DEBOUNCE_CYCLES(8),
        .CNT_W          (4),
        .DATA_BITS      (32),
        .STEP           (4),
        .REPEAT_DELAY   (20),
        .REPEAT_PERIOD  (10)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .btn       (btn),
        .clr       (clr),
        .num       (num),
        .step_pulse(step_pulse),
        .pressed   (pressed)
    );

    btn_step_counter #(
        .DEBOUNCE_CYCLES(8),
        .CNT_W          (4),
        .DATA_BITS      (4),
        .STEP           (4),
        .REPEAT_DELAY   (20),
        .REPEAT_PERIOD  (10)
    ) dut_narrow (
        .clk       (clk),
        .rst       (rst),
        .btn       (btn),
        .clr       (clr),
        .num       (num_n),
        .step_pulse(step_n),
        .pressed   (pressed_n)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;
    always @(negedge clk) if (step_pulse) pulse_cnt <= pulse_cnt + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Move to just after the next active edge, where inputs are driven.
    task automatic drive_edge();
        @(posedge clk);
        #1;
    endtask

    // Returns the edge index whose update raised step_pulse, or -1 on timeout.
    task automatic wait_pulse(output int at);
        at = -1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (step_pulse) begin
                at = edge_cnt;
                break;
            end
        end
    endtask

    task automatic wait_released(output int at);
        at = -1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!pressed) begin
                at = edge_cnt;
                break;
            end
        end
    endtask

    task automatic press_once();
        int at;
        drive_edge();
        btn = 1'b1;
        wait_pulse(at);
        repeat (5) drive_edge();
        btn = 1'b0;
        wait_released(at);
        repeat (3) drive_edge();
    endtask

    task automatic do_clr();
        drive_edge();
        clr = 1'b1;
        drive_edge();
        clr = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int k;
        int at;
        int base;

        // Reset state and clean press
        repeat (3) @(negedge clk);
        check_eq("rst_num", num, 32'd0);
        check_eq("rst_step", {31'd0, step_pulse}, 32'd0);
        check_eq("rst_pressed", {31'd0, pressed}, 32'd0);
        drive_edge();
        rst = 1'b1;
        repeat (2) drive_edge();
        btn = 1'b1;
        k = edge_cnt + 1;
        wait_pulse(at);
        check_eq("press_latency", at - k, 32'd10);
        check_eq("press_pressed_rise", {31'd0, pressed}, 32'd1);
        check_eq("press_num", num, 32'd4);
        @(negedge clk);
        check_eq("press_pulse_width", {31'd0, step_pulse}, 32'd0);
        repeat (10) drive_edge();
        btn = 1'b0;
        k = edge_cnt + 1;
        wait_released(at);
        check_eq("release_latency", at - k, 32'd10);
        check_eq("press_pulse_count", pulse_cnt, 32'd1);

        // Bounce rejection
        do_clr();
        base = pulse_cnt;
        for (int i = 0; i < 6; i++) begin
            btn = 1'b1;
            repeat (5) drive_edge();
            btn = 1'b0;
            repeat (3) drive_edge();
        end
        check_eq("bounce_no_pulse", pulse_cnt - base, 32'd0);
        check_eq("bounce_pressed", {31'd0, pressed}, 32'd0);
        btn = 1'b1;
        k = edge_cnt + 1;
        wait_pulse(at);
        check_eq("bounce_latency", at - k, 32'd10);
        check_eq("bounce_num", num, 32'd4);
        repeat (5) drive_edge();
        btn = 1'b0;
        wait_released(at);
        check_eq("bounce_pulse_count", pulse_cnt - base, 32'd1);

        // Sequence and wrap
        do_clr();
        repeat (3) press_once();
        check_eq("seq_num", num, 32'd12);
        check_eq("seq_num_narrow", {28'd0, num_n}, 32'd12);
        press_once();
        check_eq("wrap_num", num, 32'd16);
        check_eq("wrap_num_narrow", {28'd0, num_n}, 32'd0);

        // clr on the firing edge
        do_clr();
        repeat (2) press_once();
        check_eq("clr_pre_num", num, 32'd8);
        drive_edge();
        btn = 1'b1;
        k = edge_cnt + 1;
        while (edge_cnt < k + 9) drive_edge();
        clr = 1'b1;
        drive_edge();
        clr = 1'b0;
        @(negedge clk);
        check_eq("clr_step_pulse", {31'd0, step_pulse}, 32'd1);
        check_eq("clr_num", num, 32'd0);
        repeat (5) drive_edge();
        btn = 1'b0;
        wait_released(at);
        press_once();
        check_eq("clr_next_num", num, 32'd4);

        // Reset mid-press
        do_clr();
        base = pulse_cnt;
        drive_edge();
        btn = 1'b1;
        repeat (5) drive_edge();
        rst = 1'b0;
        repeat (3) drive_edge();
        check_eq("midrst_no_pulse", pulse_cnt - base, 32'd0);
        check_eq("midrst_pressed", {31'd0, pressed}, 32'd0);
        rst = 1'b1;
        k = edge_cnt + 1;
        wait_pulse(at);
        check_eq("midrst_latency", at - k, 32'd10);
        check_eq("midrst_num", num, 32'd4);
        repeat (5) drive_edge();
        btn = 1'b0;
        wait_released(at);
        repeat (3) drive_edge();

        // Long hold: auto-repeat if built in, otherwise a single step
        do_clr();
        base = pulse_cnt;
        drive_edge();
        btn = 1'b1;
        wait_pulse(k);
        while (edge_cnt < k + 55) drive_edge();
        btn = 1'b0;
        wait_released(at);
        repeat (2) drive_edge();
`ifdef AUTO_REPEAT_EN
        check_eq("hold_pulse_count", pulse_cnt - base, 32'd5);
        check_eq("hold_num", num, 32'd20);
`else
        check_eq("hold_pulse_count", pulse_cnt - base, 32'd1);
        check_eq("hold_num", num, 32'd4);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/btn_step_counter.md
Name: btn_step_counter

Overview:
- Upstream stage for the 7-segment display path.
- Takes a raw, bouncy push-button that is asynchronous to clk and synchronises and debounces it.
- Produces one clean single-cycle step pulse per press and a 32-bit step counter (num) that feeds the hex-to-segment decoders and the serial segment driver.
- Replaces clocking the counter directly from the button.

Parameters:
- DEBOUNCE_CYCLES, 1000000, cycles btn must stay stable to accept a press or release (5 ms at 200 MHz); must be >= 2
- CNT_W, 20, debounce counter width; must hold DEBOUNCE_CYCLES-1
- DATA_BITS, 32, width of num
- STEP, 4, increment added to num per accepted press
- REPEAT_DELAY, 100000000, hold cycles before first auto-repeat (AUTO_REPEAT_EN only)
- REPEAT_PERIOD, 40000000, cycles between auto-repeats (AUTO_REPEAT_EN only)

Ports:
- clk  input  1  system clock; all logic on posedge
- rst  input  1  asynchronous, active-low reset (0 = reset)
- btn  input  1  raw push-button, active high, asynchronous to clk
- clr  input  1  synchronous clear of num, active high, already in the clk domain
- num  output  DATA_BITS  step counter value
- step_pulse  output  1  high for exactly one cycle per accepted step
- pressed  output  1  debounced button level

Behaviour:
- Reset: while rst=0, asynchronously force the following to 0: synchroniser flops, FSM state (IDLE), debounce counter, num, step_pulse, pressed.
  - Reset released mid-press: the FSM restarts from IDLE, so a held button is re-debounced and counted once.
- Synchroniser: 2-flop chain; btn_s is the second flop. Nothing else samples btn.
- FSM states: IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT.
  - IDLE: if btn_s=1, go to PRESS_WAIT with cnt<=0.
  - PRESS_WAIT:
    - btn_s=0: go to IDLE (bounce rejected, no pulse).
    - btn_s=1 and cnt==DEBOUNCE_CYCLES-1: go to PRESSED and fire a step.
    - Otherwise: cnt<=cnt+1.
  - PRESSED: if btn_s=0, go to RELEASE_WAIT with cnt<=0.
  - RELEASE_WAIT:
    - btn_s=1: go back to PRESSED (no new step).
    - btn_s=0 and cnt==DEBOUNCE_CYCLES-1: go to IDLE.
    - Otherwise: cnt<=cnt+1.
- pressed: registered; it is 1 exactly when the next state is PRESSED or RELEASE_WAIT.
- Latency: if edge k is the first edge where sync flop 1 captures btn=1, and btn is held, then step_pulse is high for the one cycle following edge k+DEBOUNCE_CYCLES+2.
- Fire a step:
  - step_pulse<=1 for one cycle.
  - On the same edge, num<=num+STEP, modulo 2^DATA_BITS.
  - num wraps silently; e.g. 0xFFFFFFFC+4 = 0x00000000.
- clr:
  - On an edge with clr=1, num<=0.
  - clr has priority over a simultaneous step: num ends at 0, but step_pulse still asserts.
  - clr does not affect the FSM.
- Steps per press: at most one per press/release cycle, except under AUTO_REPEAT_EN.
- Glitches: any glitch shorter than DEBOUNCE_CYCLES on btn_s produces no step and no change to pressed.

Optional Feature:
- Macro: AUTO_REPEAT_EN.
- Defined:
  - In PRESSED, a hold counter runs.
  - After REPEAT_DELAY cycles continuously in PRESSED, fire a step; then fire one every REPEAT_PERIOD cycles while in PRESSED.
  - The hold counter resets on entering PRESSED from PRESS_WAIT.
  - The hold counter freezes, without reset, during RELEASE_WAIT and resumes if the FSM returns to PRESSED.
- Not defined: no hold counter logic is present; exactly one step per accepted press.

Test Plan:
- Reset and clean press (DEBOUNCE_CYCLES=8): hold rst=0 then release, drive btn=1 for 40 cycles, then 0 -> all outputs 0 during reset; exactly one step_pulse, high for 1 cycle, 10 edges after capture; num=4; pressed high from the same edge; pressed falls 10 edges after btn falls.
- Bounce rejection (DEBOUNCE_CYCLES=8): toggle btn 1/0 with 5-cycle high phases 6 times, then hold 1 -> no pulse during the toggling; exactly one pulse after the stable hold; num=4.
- Wrap and sequence: preload by 3 presses -> num=12. Then, with STEP=4, force num to 0xFFFFFFFC via presses or a shortened bench build, and press once -> num=0x00000000 with no error.
- clr priority: assert clr=1 on the exact cycle step_pulse would fire, starting from num=8 -> num=0 and step_pulse=1 in that cycle; the next press gives num=4.
- Reset mid-press: rst=0 during PRESS_WAIT with btn held, then release rst with btn still held -> no pulse before reset; one pulse DEBOUNCE_CYCLES+2 edges after resynchronisation; num=4.
- AUTO_REPEAT_EN (DEBOUNCE_CYCLES=8, REPEAT_DELAY=20, REPEAT_PERIOD=10): hold btn for 60 cycles past the first pulse -> pulses at +0, +20, +30, +40, +50 (+60 also if btn is still held at that edge); num=20 with 5 pulses, or 24 with 6; without the macro -> num=4.
